// File: rtl/timer_cap_pkg.sv
// ---------------------------------------------------------------------------
// timer_cap_pkg
//   Shared definitions for the timer input-capture front end.
//   - cap_evt_t : one captured event {chan, is_rise, stamp} at the default
//                 16-bit timestamp width (the packing software sees).
//   - EVT_W     : packed width of cap_evt_t.
//   - IRQ_*     : bit positions inside the 3-bit user IRQ vector.
// ---------------------------------------------------------------------------
package timer_cap_pkg;

  localparam int CHAN_W    = 2;
  localparam int CNT_W_DEF = 16;
  localparam int DEB_W     = 4;

  typedef struct packed {
    logic [CHAN_W-1:0]    chan;
    logic                 is_rise;
    logic [CNT_W_DEF-1:0] stamp;
  } cap_evt_t;

  localparam int EVT_W = $bits(cap_evt_t);

  localparam int IRQ_W      = 3;
  localparam int IRQ_NEMPTY = 0;
  localparam int IRQ_OVF    = 1;
  localparam int IRQ_FULL   = 2;

endpackage

// File: rtl/cap_debounce.sv
// ---------------------------------------------------------------------------
// cap_debounce
//   Synchroniser, debouncer and edge detector for one capture channel.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     i_pad      : raw asynchronous pad level
//     i_deb      : debounce length in cycles (0 = accept after one cycle)
//     o_rise     : one-cycle pulse in the cycle the stable level goes 0->1
//     o_fall     : one-cycle pulse in the cycle the stable level goes 1->0
//   The pulses are asserted in the same cycle the stable register is
//   updated, so the caller can timestamp with its current counter value.
// ---------------------------------------------------------------------------
module cap_debounce
  import timer_cap_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_pad,
  input  logic [DEB_W-1:0] i_deb,
  output logic             o_rise,
  output logic             o_fall
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [DEB_W-1:0] r_dc;

  logic w_diff;
  logic w_upd;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values, exactly like the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_pad;
      r_sync2 <= r_sync1;
    end
  end

  assign w_diff = r_sync2 ^ r_stable;
  // '>=' rather than '==' so that lowering i_deb below a running count
  // accepts the level at once instead of waiting for the counter to wrap.
  assign w_upd  = w_diff && (r_dc >= i_deb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= 1'b0;
      r_dc     <= '0;
    end else if (w_upd) begin
      r_stable <= r_sync2;
      r_dc     <= '0;
    end else if (w_diff) begin
      r_dc     <= r_dc + 1'b1;
    end else begin
      r_dc     <= '0;
    end
  end

  assign o_rise = w_upd &  r_sync2;
  assign o_fall = w_upd & ~r_sync2;

endmodule

// File: rtl/timer_capture_unit.sv
// ---------------------------------------------------------------------------
// timer_capture_unit
//   Input-capture front end for the user-area timer. Each channel is
//   synchronised and debounced; enabled edges are timestamped with a
//   free-running counter, held in a one-deep per-channel pending register,
//   and moved by a fixed-priority arbiter (lowest channel first) into a
//   first-word-fall-through event FIFO.
//   Ports:
//     wb_clk_i, wb_rst_ni : clock, asynchronous active-low reset
//     cap_in              : raw pad inputs, one per channel
//     cfg_en/rise/fall    : per-channel enable and edge selection
//     cfg_deb             : debounce length in cycles (shared)
//     evt_valid/ready     : FIFO head handshake (pop on valid && ready)
//     evt_chan/edge/stamp : head event (edge 1 = rising)
//     ov_clr, overflow    : clear / sticky event-loss flag
//     irq                 : [0] non-empty, [1] overflow, [2] full (registered)
//   DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module timer_capture_unit
  import timer_cap_pkg::*;
#(
  parameter int CH    = 4,
  parameter int CNT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic [CH-1:0]    cap_in,
  input  logic [CH-1:0]    cfg_en,
  input  logic [CH-1:0]    cfg_rise,
  input  logic [CH-1:0]    cfg_fall,
  input  logic [DEB_W-1:0] cfg_deb,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CHAN_W-1:0] evt_chan,
  output logic             evt_edge,
  output logic [CNT_W-1:0] evt_stamp,
  input  logic             ov_clr,
  output logic             overflow,
  output logic [IRQ_W-1:0] irq
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic              is_rise;
    logic [CNT_W-1:0]  stamp;
  } evt_t;

  // ---------------- per-channel sync / debounce / edge ----------------
  logic [CH-1:0] w_rise;
  logic [CH-1:0] w_fall;
  logic [CH-1:0] w_rec;
  logic [CH-1:0] w_drop;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    cap_debounce u_deb (
      .clk    (wb_clk_i),
      .rst_n  (wb_rst_ni),
      .i_pad  (cap_in[g]),
      .i_deb  (cfg_deb),
      .o_rise (w_rise[g]),
      .o_fall (w_fall[g])
    );
  end

  // Disabling a channel only gates new recordings; debounce keeps tracking.
  assign w_rec = cfg_en & ((w_rise & cfg_rise) | (w_fall & cfg_fall));

  // ---------------- timestamp counter ----------------
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_cnt <= '0;
    else            r_cnt <= r_cnt + 1'b1;
  end

  // ---------------- pending registers ----------------
  logic [CH-1:0]    r_pend_v;
  logic [CH-1:0]    r_pend_rise;
  logic [CNT_W-1:0] r_pend_stamp [CH];

  // An occupied slot rejects a new edge even if the arbiter is draining it
  // in this same cycle; the new edge is lost and flagged.
  assign w_drop = w_rec & r_pend_v;

  // ---------------- priority arbiter ----------------
  logic              w_gnt_v;
  logic [CHAN_W-1:0] w_gnt_idx;
  logic              w_gnt_rise;
  logic [CNT_W-1:0]  w_gnt_stamp;

  // NOTE: every output of this block gets a default before the loop, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_gnt_v     = 1'b0;
    w_gnt_idx   = '0;
    w_gnt_rise  = 1'b0;
    w_gnt_stamp = '0;
    // Scan downwards so the lowest pending index is the last writer.
    for (int c = CH - 1; c >= 0; c--) begin
      if (r_pend_v[c]) begin
        w_gnt_v     = 1'b1;
        w_gnt_idx   = CHAN_W'(c);
        w_gnt_rise  = r_pend_rise[c];
        w_gnt_stamp = r_pend_stamp[c];
      end
    end
  end

  // ---------------- FIFO control ----------------
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_full    = (r_count == FULL_CNT);
  // Full blocks the push even when a pop frees a slot in the same cycle.
  assign w_push    = w_gnt_v && !w_full;
  assign evt_valid = (r_count != '0);
  assign w_pop     = evt_valid && evt_ready;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_pend_v    <= '0;
      r_pend_rise <= '0;
      for (int c = 0; c < CH; c++) r_pend_stamp[c] <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (w_push && (w_gnt_idx == CHAN_W'(c))) begin
          r_pend_v[c] <= 1'b0;
        end else if (w_rec[c] && !r_pend_v[c]) begin
          r_pend_v[c]     <= 1'b1;
          r_pend_rise[c]  <= w_rise[c];
          r_pend_stamp[c] <= r_cnt;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- FIFO storage ----------------
  evt_t r_mem [DEPTH];
  evt_t w_head;

  // NOTE: the storage array has no reset; an entry is only ever read after
  // it was written, and the outputs below are forced to 0 while empty.
  always_ff @(posedge wb_clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{chan: w_gnt_idx, is_rise: w_gnt_rise, stamp: w_gnt_stamp};
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign evt_chan  = evt_valid ? w_head.chan    : '0;
  assign evt_edge  = evt_valid ? w_head.is_rise : 1'b0;
  assign evt_stamp = evt_valid ? w_head.stamp   : '0;

  // ---------------- overflow flag and IRQ ----------------
  logic             r_ovf;
  logic [IRQ_W-1:0] r_irq;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ovf <= 1'b0;
    end else if (|w_drop) begin
      r_ovf <= 1'b1;            // a loss wins over a simultaneous clear
    end else if (ov_clr) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_irq <= '0;
    end else begin
      r_irq[IRQ_NEMPTY] <= evt_valid;
      r_irq[IRQ_OVF]    <= r_ovf;
      r_irq[IRQ_FULL]   <= w_full;
    end
  end

  assign overflow = r_ovf;
  assign irq      = r_irq;

endmodule
